dac_scan_sequencer: RTL and testbench

- Scan controller for the MCP4921 SPI DAC path.
- Walks the 12-bit DAC code from a start value to a stop value in fixed increments.
- For each point it issues one load strobe to the SPI DAC master and waits for that master's completion pulse. It then opens a counting window of programmable length before advancing.
- Sits between the register file and the SPI DAC master. It replaces manual per-step writes with an autonomous threshold/voltage scan.

---
 rtl/dac_scan_sequencer_if.sv | 11 +
 rtl/dac_scan_sequencer.sv | 147 ++++++++++++++
 tb/tb_dac_scan_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_scan_sequencer_if.sv
// Load/ack handshake between the scan sequencer and the SPI DAC master.
interface dac_scan_sequencer_if #(
  parameter int CODE_WIDTH = 12
) ();
  logic [CODE_WIDTH-1:0] dac_code;
  logic                  dac_load;
  logic                  dac_done;

  modport master (output dac_code, output dac_load, input dac_done);
  modport slave  (input dac_code, input dac_load, output dac_done);
endinterface

// File: rtl/dac_scan_sequencer.sv
// Autonomous DAC code scan: load each code, wait for the SPI master's ack,
// hold a counting window, then step to the next code until the stop code.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; cfg latched on an accepted start
// LOAD     | one-cycle dac_load strobe for the current code
// WAIT_ACK | waiting for dac_done, bounded by the ack timeout
// DWELL    | counting window open for max(dwell,1) cycles
// NEXT     | compute next code; finish or go back to LOAD
module dac_scan_sequencer #(
  parameter int CODE_WIDTH  = 12,
  parameter int DWELL_WIDTH = 16,
  parameter int IDX_WIDTH   = 12,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CODE_WIDTH-1:0]  cfg_start_code,
  input  logic [CODE_WIDTH-1:0]  cfg_stop_code,
  input  logic [CODE_WIDTH-1:0]  cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  dac_scan_sequencer_if.master   dac,
  output logic                   window,
  output logic                   point_done,
  output logic [IDX_WIDTH-1:0]   step_index,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   err_timeout
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, DWELL, NEXT} state_t;

  state_t                 state, state_n;
  logic [CODE_WIDTH-1:0]  code_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_cnt, dwell_eff;
  logic [TO_W-1:0]        to_cnt;
  logic [CODE_WIDTH:0]    sum;
  logic                   scan_end;
  logic                   load;
  logic                   accept;

  assign accept    = start && !abort;
  assign dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
  assign sum       = {1'b0, code_q} + {1'b0, step_q};
  // A carry out of the code width ends the scan rather than wrapping to low codes.
  assign scan_end  = (step_q == '0) || sum[CODE_WIDTH] || (sum[CODE_WIDTH-1:0] > stop_q);

  assign dac.dac_code = code_q;
  assign dac.dac_load = load;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and strobe outputs; abort overrides everything outside IDLE.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    window     = 1'b0;
    point_done = 1'b0;
    scan_done  = 1'b0;
    case (state)
      IDLE:     if (accept) state_n = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dac.dac_done)      state_n = DWELL;
        else if (to_cnt == '0) state_n = IDLE;
      end
      DWELL: begin
        window = 1'b1;
        if (dwell_cnt == DWELL_WIDTH'(1)) begin
          point_done = 1'b1;
          state_n    = NEXT;
        end
      end
      NEXT: begin
        if (scan_end) begin
          scan_done = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = LOAD;
        end
      end
      default:  state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_n    = IDLE;
      point_done = 1'b0;
      scan_done  = 1'b0;
    end
  end

  // Datapath: config latch, code/index stepping, ack timeout and dwell timers.
  always_ff @(posedge clk) begin
    if (res) begin
      code_q      <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt   <= '0;
      to_cnt      <= '0;
      step_index  <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            code_q      <= cfg_start_code;
            stop_q      <= cfg_stop_code;
            step_q      <= cfg_step;
            dwell_q     <= cfg_dwell;
            step_index  <= '0;
            err_timeout <= 1'b0;
          end
        end
        LOAD:     to_cnt <= TO_W'(ACK_TIMEOUT - 1);
        WAIT_ACK: begin
          if (!abort) begin
            if (dac.dac_done)      dwell_cnt   <= dwell_eff;
            else if (to_cnt == '0) err_timeout <= 1'b1;
            else                   to_cnt      <= to_cnt - 1'b1;
          end
        end
        DWELL:    if (!abort) dwell_cnt <= dwell_cnt - 1'b1;
        NEXT: begin
          if (!abort && !scan_end) begin
            code_q     <= sum[CODE_WIDTH-1:0];
            step_index <= step_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Directed bench for dac_scan_sequencer with a simple SPI-master ack model.
module tb_dac_scan_sequencer;
  localparam int CW = 12;
  localparam int DW = 16;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_start_code = '0;
  logic [CW-1:0] cfg_stop_code = '0;
  logic [CW-1:0] cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          window, point_done, busy, scan_done, err_timeout;
  logic [IW-1:0] step_index;

  dac_scan_sequencer_if #(.CODE_WIDTH(CW)) ifc ();

  dac_scan_sequencer dut (
    .clk            (clk),
    .res            (res),
    .start          (start),
    .abort          (abort),
    .cfg_start_code (cfg_start_code),
    .cfg_stop_code  (cfg_stop_code),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .dac            (ifc),
    .window         (window),
    .point_done     (point_done),
    .step_index     (step_index),
    .busy           (busy),
    .scan_done      (scan_done),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  // Ack model: dac_done pulses ack_delay cycles after each dac_load.
  logic ack_pulse = 1'b0;
  logic man_done  = 1'b0;
  bit   ack_en    = 1'b1;
  int   ack_delay = 5;
  int   ack_cnt   = 0;
  assign ifc.dac_done = ack_pulse | man_done;

  always @(posedge clk) begin
    #1;
    ack_pulse = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt = ack_cnt - 1;
      if (ack_cnt == 0) ack_pulse = 1'b1;
    end
    if (ack_en && ifc.dac_load) ack_cnt = ack_delay;
  end

  // Monitor, sampled mid-cycle.
  int n_load = 0, n_pd = 0, n_sd = 0, win_run = 0;
  int codes[$];
  int idxs[$];
  int wins[$];

  always @(negedge clk) begin
    if (ifc.dac_load) begin
      n_load = n_load + 1;
      codes.push_back(int'(ifc.dac_code));
      idxs.push_back(int'(step_index));
    end
    if (point_done) n_pd = n_pd + 1;
    if (scan_done)  n_sd = n_sd + 1;
    if (window) win_run = win_run + 1;
    else if (win_run > 0) begin
      wins.push_back(win_run);
      win_run = 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int b_load, b_pd, b_sd, b_win;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_load = n_load;
    b_pd   = n_pd;
    b_sd   = n_sd;
    b_win  = wins.size();
  endtask

  function automatic int code_at(input int i);
    return (b_load + i < codes.size()) ? codes[b_load + i] : -1;
  endfunction

  function automatic int idx_at(input int i);
    return (b_load + i < idxs.size()) ? idxs[b_load + i] : -1;
  endfunction

  function automatic int win_at(input int i);
    return (b_win + i < wins.size()) ? wins[b_win + i] : -1;
  endfunction

  task automatic set_cfg(input int s, input int e, input int st, input int dw);
    cfg_start_code = CW'(s);
    cfg_stop_code  = CW'(e);
    cfg_step       = CW'(st);
    cfg_dwell      = DW'(dw);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk(tag, int'(busy), 0);
  endtask

  task automatic run_scan(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(tag, 2000);
  endtask

  initial begin
    int n;
    // Reset
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_code", int'(ifc.dac_code), 0);
    chk("rst_idx", int'(step_index), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_load", int'(ifc.dac_load), 0);
    chk("rst_window", int'(window), 0);

    // Basic scan 100..130 step 10, dwell 4, ack after 5
    set_cfg(100, 130, 10, 4);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(0, 0, 0, 0);
    chk("t1_load_lat", int'(ifc.dac_load), 1);
    chk("t1_code0", int'(ifc.dac_code), 100);
    chk("t1_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t1_win_before_ack", int'(window), 0);
    tick();
    chk("t1_win_after_ack", int'(window), 1);
    wait_idle("t1_idle", 500);
    chk("t1_nload", n_load - b_load, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_code%0d", i), code_at(i), 100 + 10 * i);
      chk($sformatf("t1_idx%0d", i), idx_at(i), i);
      chk($sformatf("t1_win%0d", i), win_at(i), 4);
    end
    chk("t1_nwin", wins.size() - b_win, 4);
    chk("t1_npd", n_pd - b_pd, 4);
    chk("t1_nsd", n_sd - b_sd, 1);
    chk("t1_final_code", int'(ifc.dac_code), 130);

    // Top-of-range overflow
    set_cfg(4090, 4095, 10, 2);
    snap();
    run_scan("t2_idle");
    chk("t2_nload", n_load - b_load, 1);
    chk("t2_code", code_at(0), 4090);
    chk("t2_nsd", n_sd - b_sd, 1);
    chk("t2_final_code", int'(ifc.dac_code), 4090);

    // Step zero
    set_cfg(50, 200, 0, 1);
    snap();
    run_scan("t2b_idle");
    chk("t2b_nload", n_load - b_load, 1);
    chk("t2b_code", code_at(0), 50);
    chk("t2b_nsd", n_sd - b_sd, 1);

    // Dwell 0 and start > stop
    set_cfg(500, 200, 5, 0);
    snap();
    run_scan("t3_idle");
    chk("t3_nload", n_load - b_load, 1);
    chk("t3_code", code_at(0), 500);
    chk("t3_win", win_at(0), 1);
    chk("t3_npd", n_pd - b_pd, 1);
    chk("t3_nsd", n_sd - b_sd, 1);

    // Ack timeout
    ack_en = 1'b0;
    set_cfg(700, 800, 10, 3);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_load", int'(ifc.dac_load), 1);
    for (int i = 0; i < 1000; i++) tick();
    chk("t4_err_early", int'(err_timeout), 0);
    chk("t4_busy_early", int'(busy), 1);
    for (int i = 0; i < 30; i++) tick();
    chk("t4_err", int'(err_timeout), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_nsd", n_sd - b_sd, 0);
    ack_en = 1'b1;
    set_cfg(10, 10, 1, 1);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_clr", int'(err_timeout), 0);
    wait_idle("t4b_idle", 500);
    chk("t4b_nsd", n_sd - b_sd, 1);

    // Abort during DWELL of point 2
    set_cfg(0, 40, 10, 6);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(step_index == IW'(2) && window) && n < 500) begin
      tick();
      n++;
    end
    chk("t5_reach_pt2", int'(window), 1);
    tick();
    tick();
    chk("t5_npd_before", n_pd - b_pd, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_window", int'(window), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_load", int'(ifc.dac_load), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_npd", n_pd - b_pd, 2);
    chk("t5_nsd", n_sd - b_sd, 0);
    chk("t5_nload", n_load - b_load, 3);
    chk("t5_code", int'(ifc.dac_code), 20);

    // Simultaneous start + abort in IDLE
    set_cfg(0, 40, 10, 1);
    snap();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5b_busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5b_nload", n_load - b_load, 0);

    // Reset during WAIT_ACK
    ack_en = 1'b0;
    set_cfg(300, 400, 50, 3);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_in_wait", int'(busy), 1);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_code", int'(ifc.dac_code), 0);
    chk("t6_idx", int'(step_index), 0);
    chk("t6_err", int'(err_timeout), 0);
    chk("t6_window", int'(window), 0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    tick();
    chk("t6_done_ignored", int'(busy), 0);
    chk("t6_nload", n_load - b_load, 1);
    ack_en = 1'b1;
    snap();
    run_scan("t6b_idle");
    chk("t6b_nload", n_load - b_load, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t6b_code%0d", i), code_at(i), 300 + 50 * i);
    chk("t6b_nsd", n_sd - b_sd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
